// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: segment pattern type, hex glyph table and
// the frame output state encoding.
package seg7_pkg;

    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG7_BLANK = 7'h00;

    // Active-high {a,b,c,d,e,f,g} glyphs for nibbles 0..F.
    localparam seg7_t SEG7_HEX [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };

    typedef enum logic {EMPTY, FULL} out_state_t;

endpackage

// File: rtl/seg7_to_hex.sv
// Inverse 7-segment decoder: maps a segment pattern back to its nibble and
// flags patterns that are not one of the sixteen hex glyphs.
module seg7_to_hex
    import seg7_pkg::*;
(
    input  seg7_t      seg,
    output logic [3:0] nibble,
    output logic       legal
);

    always_comb begin
        nibble = '0;
        legal  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (seg == SEG7_HEX[i]) begin
                nibble = 4'(i);
                legal  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg7_hex_capture.sv
// Captures hex digits from a scanned 7-segment bus into whole frames and
// offers each frame to a consumer over valid/ready.
module seg7_hex_capture
    import seg7_pkg::*;
#(
    parameter int N_DIGITS   = 4,
    parameter int STABLE_CYC = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            seg,
    input  logic [N_DIGITS-1:0]   dig_sel,
    output logic [4*N_DIGITS-1:0] frm_hex,
    output logic                  frm_valid,
    input  logic                  frm_ready,
    output logic [N_DIGITS-1:0]   frm_err,
    output logic                  ovf
);

    localparam int CNT_W = $clog2(STABLE_CYC + 1);

    seg7_t                 seg_p0, s_seg, prev_seg;
    logic [N_DIGITS-1:0]   sel_p0, s_sel, prev_sel;
    logic [CNT_W-1:0]      stab_cnt;
    logic [N_DIGITS-1:0]   seen;
    logic [4*N_DIGITS-1:0] slot_hex, slot_hex_nxt;
    logic [N_DIGITS-1:0]   slot_err, slot_err_nxt;
    logic                  frm_done_p1;
    out_state_t            state;

    logic                  changed, sel_onehot, capture, frame_done;
    logic [N_DIGITS-1:0]   cap_mask;
    logic [3:0]            dec_nib;
    logic                  dec_legal;

    // Stage p0/p1: two-flop synchronizer on the asynchronous display bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_p0 <= SEG7_BLANK;
            s_seg  <= SEG7_BLANK;
            sel_p0 <= '0;
            s_sel  <= '0;
        end else begin
            seg_p0 <= seg;
            s_seg  <= seg_p0;
            sel_p0 <= dig_sel;
            s_sel  <= sel_p0;
        end
    end

    assign changed    = {s_sel, s_seg} != {prev_sel, prev_seg};
    assign sel_onehot = (s_sel != '0) && ((s_sel & (s_sel - N_DIGITS'(1))) == '0);
    assign capture    = !changed && sel_onehot && (s_seg != SEG7_BLANK)
                        && (stab_cnt == CNT_W'(STABLE_CYC - 1));
    assign cap_mask   = capture ? s_sel : '0;
    assign frame_done = capture && (&(seen | cap_mask));

    seg7_to_hex u_dec (
        .seg    (s_seg),
        .nibble (dec_nib),
        .legal  (dec_legal)
    );

    always_comb begin
        slot_hex_nxt = slot_hex;
        slot_err_nxt = slot_err;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (cap_mask[i]) begin
                slot_hex_nxt[4*i +: 4] = dec_nib;
                slot_err_nxt[i]        = !dec_legal;
            end
        end
    end

    // Stage p2: dwell counter, digit slots and frame completion strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_seg    <= SEG7_BLANK;
            prev_sel    <= '0;
            stab_cnt    <= '0;
            seen        <= '0;
            slot_hex    <= '0;
            slot_err    <= '0;
            frm_done_p1 <= 1'b0;
        end else begin
            prev_seg <= s_seg;
            prev_sel <= s_sel;
            if (changed)
                stab_cnt <= '0;
            else if (stab_cnt != CNT_W'(STABLE_CYC))
                stab_cnt <= stab_cnt + CNT_W'(1);
            slot_hex    <= slot_hex_nxt;
            slot_err    <= slot_err_nxt;
            seen        <= frame_done ? '0 : (seen | cap_mask);
            frm_done_p1 <= frame_done;
        end
    end

    // Stage p3: output frame register; a frame arriving while stalled is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= EMPTY;
            frm_hex <= '0;
            frm_err <= '0;
            ovf     <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (frm_done_p1) begin
                        state   <= FULL;
                        frm_hex <= slot_hex;
                        frm_err <= slot_err;
                    end
                end
                FULL: begin
                    if (frm_ready)
                        ovf <= 1'b0;
                    if (frm_done_p1) begin
                        if (frm_ready) begin
                            frm_hex <= slot_hex;
                            frm_err <= slot_err;
                        end else begin
                            ovf <= 1'b1;
                        end
                    end else if (frm_ready) begin
                        state <= EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    assign frm_valid = (state == FULL);

endmodule

// File: tb/tb_seg7_hex_capture.sv
// Directed bench for seg7_hex_capture with a sliding-window reference model
// compared every cycle, plus literal checks on frames and timing.
module tb_seg7_hex_capture;

    localparam int N = 4;
    localparam int S = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [6:0]     seg = '0;
    logic [N-1:0]   dig_sel = '0;
    logic           frm_ready = 1'b0;
    logic [4*N-1:0] frm_hex;
    logic           frm_valid;
    logic [N-1:0]   frm_err;
    logic           ovf;

    always #5 clk = ~clk;

    seg7_hex_capture #(.N_DIGITS(N), .STABLE_CYC(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seg       (seg),
        .dig_sel   (dig_sel),
        .frm_hex   (frm_hex),
        .frm_valid (frm_valid),
        .frm_ready (frm_ready),
        .frm_err   (frm_err),
        .ovf       (ovf)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model: a digit is taken when the pin value sampled at edge k-2
    // has been identical for S+1 samples and differed just before that run.
    localparam logic [6:0] GLYPH [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };

    logic [N+6:0]   hist [0:S+3];
    logic [3:0]     m_slot [N];
    logic           m_slot_err [N];
    logic [N-1:0]   m_seen;
    logic           m_pend;
    logic           m_valid;
    logic [4*N-1:0] m_hex;
    logic [N-1:0]   m_err;
    logic           m_ovf;
    int             last_cap_cyc;

    always @(posedge clk or negedge rst_n) begin
        logic       run, cap_now, done, drop, acc, legal;
        logic [3:0] nib;
        int         d;
        if (!rst_n) begin
            for (int i = 0; i <= S+3; i++) hist[i] = '0;
            for (int i = 0; i < N; i++) begin
                m_slot[i] = '0;
                m_slot_err[i] = 1'b0;
            end
            m_seen = '0; m_pend = 1'b0; m_valid = 1'b0;
            m_hex = '0; m_err = '0; m_ovf = 1'b0;
        end else begin
            for (int i = S+3; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = {dig_sel, seg};
            run = 1'b1;
            for (int i = 3; i <= S+2; i++) if (hist[i] !== hist[2]) run = 1'b0;
            cap_now = run && (hist[S+3] !== hist[2])
                      && ($countones(hist[2][N+6:7]) == 1) && (hist[2][6:0] != 7'h00);
            // Frame output step acts on the completion found one edge earlier.
            acc  = m_valid && frm_ready;
            drop = m_pend && m_valid && !frm_ready;
            if (acc) m_ovf = 1'b0;
            if (drop) m_ovf = 1'b1;
            else if (m_pend) begin
                m_valid = 1'b1;
                for (int i = 0; i < N; i++) begin
                    m_hex[4*i +: 4] = m_slot[i];
                    m_err[i] = m_slot_err[i];
                end
            end else if (acc) m_valid = 1'b0;
            done = 1'b0;
            if (cap_now) begin
                nib = '0; legal = 1'b0; d = 0;
                for (int n = 0; n < 16; n++)
                    if (GLYPH[n] == hist[2][6:0]) begin nib = 4'(n); legal = 1'b1; end
                for (int i = 0; i < N; i++) if (hist[2][7+i]) d = i;
                m_slot[d] = nib;
                m_slot_err[d] = !legal;
                m_seen[d] = 1'b1;
                last_cap_cyc = cyc + 1;
                if (&m_seen) begin done = 1'b1; m_seen = '0; end
            end
            m_pend = done;
        end
    end

    always @(negedge clk) begin
        check("cmp_valid", frm_valid, m_valid);
        check("cmp_hex",   frm_hex,   m_hex);
        check("cmp_err",   frm_err,   m_err);
        check("cmp_ovf",   ovf,       m_ovf);
    end

    // mode 0: plain; 1: check frm_valid rises the cycle after capture;
    // 2: raise frm_ready only for the edge the completed frame is offered.
    task automatic show(input int d, input logic [6:0] p, input int hold,
                        input int mode, output int t);
        dig_sel = '0;
        dig_sel[d] = 1'b1;
        seg = p;
        t = cyc + 1;
        for (int k = 0; k < hold; k++) begin
            if (mode == 2) frm_ready = (cyc == t + S + 2);
            @(negedge clk);
            if (mode == 1 && cyc == t + S + 2) check("lat_before", frm_valid, 0);
            if (mode == 1 && cyc == t + S + 3) check("lat_after", frm_valid, 1);
        end
        if (mode == 2) frm_ready = 1'b0;
        seg = '0;
        dig_sel = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic accept();
        frm_ready = 1'b1;
        @(negedge clk);
        frm_ready = 1'b0;
    endtask

    initial begin
        repeat (30000) @(posedge clk);
        $display("FAIL watchdog: got no finish expected finish within 30000 cycles");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, cap_prev;
        repeat (3) @(negedge clk);
        check("rst_valid", frm_valid, 0);
        check("rst_hex", frm_hex, 0);
        check("rst_err", frm_err, 0);
        check("rst_ovf", ovf, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Clean frame
        show(0, 7'h5B, 12, 0, t);
        show(1, 7'h7E, 12, 0, t);
        show(2, 7'h4F, 12, 0, t);
        show(3, 7'h3D, 12, 1, t);
        check("clean_hex", frm_hex, 16'hDE05);
        check("clean_err", frm_err, 0);
        accept();
        check("clean_acc_valid", frm_valid, 0);

        // Short dwell on the last digit, then a long enough one
        show(0, 7'h30, 12, 0, t);
        show(2, 7'h6D, 12, 0, t);
        show(3, 7'h79, 12, 0, t);
        cap_prev = last_cap_cyc;
        show(1, 7'h33, S, 0, t);
        repeat (4) @(negedge clk);
        check("short_valid", frm_valid, 0);
        check("short_model_nocap", last_cap_cyc, cap_prev);
        show(1, 7'h33, 12, 1, t);
        check("dwell_cap_edge", last_cap_cyc, t + S + 2);
        check("dwell_hex", frm_hex, 16'h3241);
        accept();

        // Illegal pattern on digit 2
        show(0, 7'h7F, 12, 0, t);
        show(1, 7'h7B, 12, 0, t);
        show(2, 7'h01, 12, 0, t);
        show(3, 7'h77, 12, 0, t);
        check("illegal_hex", frm_hex, 16'hA098);
        check("illegal_err", frm_err, 4'b0100);
        check("illegal_nib2", frm_hex[11:8], 0);
        accept();

        // Stall across two frames
        show(0, 7'h4E, 12, 0, t);
        show(1, 7'h1F, 12, 0, t);
        show(2, 7'h47, 12, 0, t);
        show(3, 7'h5F, 12, 0, t);
        check("stall_a_hex", frm_hex, 16'h6FBC);
        check("stall_a_ovf", ovf, 0);
        show(0, 7'h70, 12, 0, t);
        show(1, 7'h30, 12, 0, t);
        show(2, 7'h6D, 12, 0, t);
        show(3, 7'h79, 12, 0, t);
        check("stall_held_hex", frm_hex, 16'h6FBC);
        check("stall_valid", frm_valid, 1);
        check("stall_ovf", ovf, 1);
        accept();
        check("stall_acc_valid", frm_valid, 0);
        check("stall_acc_ovf", ovf, 0);

        // Accept on the completion cycle
        show(0, 7'h30, 12, 0, t);
        show(1, 7'h6D, 12, 0, t);
        show(2, 7'h79, 12, 0, t);
        show(3, 7'h33, 12, 0, t);
        check("b2b_first_hex", frm_hex, 16'h4321);
        show(0, 7'h7E, 12, 0, t);
        show(1, 7'h7E, 12, 0, t);
        show(2, 7'h7E, 12, 0, t);
        show(3, 7'h5B, 12, 2, t);
        check("b2b_valid", frm_valid, 1);
        check("b2b_hex", frm_hex, 16'h5000);
        check("b2b_ovf", ovf, 0);
        accept();

        // Reset in the middle of a scan
        show(0, 7'h4F, 12, 0, t);
        show(1, 7'h4F, 12, 0, t);
        #2 rst_n = 1'b0;
        #1;
        check("mrst_hex", frm_hex, 0);
        check("mrst_valid", frm_valid, 0);
        check("mrst_ovf", ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;
        show(2, 7'h6D, 12, 0, t);
        show(3, 7'h79, 12, 0, t);
        check("mrst_no_stale", frm_valid, 0);
        show(0, 7'h7E, 12, 0, t);
        show(1, 7'h30, 12, 1, t);
        check("mrst_hex_new", frm_hex, 16'h3210);
        check("mrst_err_new", frm_err, 0);
        accept();
        repeat (20) @(negedge clk);
        check("mrst_one_frame", frm_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
